// File: rtl/audio_i2s_transmitter.sv
// audio_i2s_transmitter: serialises a mono sample to both I2S slots and paces the producer with sample_clk
module audio_i2s_transmitter #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              enable,
  input  logic              mute,
  input  logic [DATA_W-1:0] audio_data,
  input  logic              data_valid,
  output logic              sample_clk,
  output logic              underrun,
  output logic              AUD_BCLK,
  output logic              AUD_DACLRCK,
  output logic              AUD_DACDAT
);
  localparam int DIV_W = $clog2(BCLK_DIV + 1);
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt, bit_nx, p;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] tx_word, next_word;
  logic              wrap, fall, dat_nx;

  // run/idle state register
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= state_nx;

  // next state plus divider/bit-position decode for the upcoming falling event
  always_comb begin
    state_nx = enable ? RUN : IDLE;
    wrap     = (state == RUN) && enable && (div_cnt == DIV_W'(BCLK_DIV - 1));
    fall     = wrap && AUD_BCLK;
    bit_nx   = (bit_cnt == BIT_W'(2 * SLOT_W - 1)) ? '0 : bit_cnt + BIT_W'(1);
    p        = (bit_nx >= BIT_W'(SLOT_W)) ? bit_nx - BIT_W'(SLOT_W) : bit_nx;
    idx      = IDX_W'(DATA_W - int'(p));
    dat_nx   = (p != '0) && (p <= BIT_W'(DATA_W)) ? tx_word[idx] : 1'b0;
  end

  // clock generation, serialisation, frame-start load and mid-frame capture
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx_word     <= '0;
      next_word   <= '0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
      sample_clk  <= 1'b0;
      underrun    <= 1'b0;
    end else if (state_nx == IDLE || state == IDLE) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
      sample_clk  <= 1'b0;
      underrun    <= 1'b0;
      if (state_nx == RUN) tx_word <= next_word;
    end else begin
      div_cnt    <= wrap ? '0 : div_cnt + DIV_W'(1);
      AUD_BCLK   <= wrap ? ~AUD_BCLK : AUD_BCLK;
      sample_clk <= fall && (bit_nx == '0);
      underrun   <= fall && (bit_nx == BIT_W'(SLOT_W)) && !data_valid;
      if (fall) begin
        bit_cnt     <= bit_nx;
        AUD_DACLRCK <= bit_nx >= BIT_W'(SLOT_W);
        AUD_DACDAT  <= dat_nx;
        if (bit_nx == '0) tx_word <= next_word;
        if (bit_nx == BIT_W'(SLOT_W) && (data_valid || mute)) next_word <= mute ? '0 : audio_data;
      end
    end
endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// tb_audio_i2s_transmitter: randomized I2S transmitter bench against a time-based frame model
module tb_audio_i2s_transmitter;
  localparam int W = 16;
  localparam int S = 32;
  localparam int D = 8;
  localparam int F = 2 * S * 2 * D;

  logic          Clk = 0;
  logic          Reset = 1;
  logic          enable = 0;
  logic          mute = 0;
  logic          data_valid = 0;
  logic [W-1:0]  audio_data = '0;
  logic          sample_clk, underrun, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;

  int            n_cmp = 0;
  int            n_bad = 0;

  bit            run = 0;
  bit            und = 0;
  int            t = 0;
  logic [W-1:0]  mword = '0;
  logic [W-1:0]  cur = '0;

  audio_i2s_transmitter #(.DATA_W(W), .SLOT_W(S), .BCLK_DIV(D)) dut (
    .Clk(Clk), .Reset(Reset), .enable(enable), .mute(mute),
    .audio_data(audio_data), .data_valid(data_valid),
    .sample_clk(sample_clk), .underrun(underrun),
    .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: t counts clocks since RUN entry; every frame is F clocks, capture halfway through.
  initial forever begin
    @(posedge Clk);
    und = 0;
    if (!Reset) begin
      run = 0; t = 0; mword = '0; cur = '0;
    end else if (!enable) begin
      run = 0; t = 0;
    end else if (!run) begin
      run = 1; t = 0; cur = mword;
    end else begin
      t++;
      if (t % F == 0) cur = mword;
      if (t % F == F / 2) begin
        und = !data_valid;
        if (data_valid || mute) mword = mute ? '0 : audio_data;
      end
    end
  end

  initial begin
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        chk("rst_bclk", AUD_BCLK, 0);
        chk("rst_lrck", AUD_DACLRCK, 0);
        chk("rst_dat", AUD_DACDAT, 0);
        chk("rst_sc", sample_clk, 0);
        chk("rst_und", underrun, 0);
      end else begin
        automatic int k = (t / (2 * D)) % (2 * S);
        automatic int p = k % S;
        chk("bclk", AUD_BCLK, run && ((t / D) % 2 == 1));
        chk("lrck", AUD_DACLRCK, run && (k >= S));
        chk("dat", AUD_DACDAT, run && p >= 1 && p <= W && cur[W-p]);
        chk("sc", sample_clk, run && t > 0 && (t % F == 0));
        chk("und", underrun, run && und);
      end
    end
  end

  task automatic run_to_sc(output int u, output int c);
    u = 0; c = 0;
    do begin
      @(negedge Clk);
      c++;
      if (underrun) u++;
    end while (!sample_clk && c < 2 * F);
    chk("sc_wait", sample_clk, 1);
  endtask

  task automatic collect(output logic [63:0] b);
    logic prev;
    int k, i;
    k = 0; i = 0; b = '0; prev = AUD_BCLK;
    while (k < 64 && i < 2 * F) begin
      @(negedge Clk);
      i++;
      if (!prev && AUD_BCLK) begin
        b = {b[62:0], AUD_DACDAT};
        k++;
      end
      prev = AUD_BCLK;
    end
    chk("collect_bits", k, 64);
  endtask

  task automatic check_frame(input string nm, input logic [W-1:0] w);
    logic [63:0] b;
    collect(b);
    chk({nm, "_left"}, b[62:47], w);
    chk({nm, "_right"}, b[30:15], w);
    chk({nm, "_pad"}, {b[63], b[46:31], b[14:0]}, 0);
  endtask

  task automatic first_rise();
    int n, m;
    n = 0; m = 0;
    enable = 1;
    @(posedge Clk);
    do begin
      @(posedge Clk);
      n++;
      #1;
    end while (!AUD_BCLK && n < 50);
    chk("first_rise", n, D);
    @(negedge Clk);
    do begin
      @(negedge Clk);
      m++;
    end while (!(AUD_BCLK && m > D) && m < 50);
    chk("bclk_period", m, 2 * D);
  endtask

  initial begin
    int u, c, z;
    #1 Reset = 0;
    repeat (3) @(negedge Clk);
    Reset = 1;
    @(negedge Clk);
    chk("idle_bclk", AUD_BCLK, 0);
    chk("idle_sc", sample_clk, 0);
    first_rise();
    run_to_sc(u, c);
    chk("first_frame_underrun", u, 1);
    audio_data = 16'hA5C3; data_valid = 1;
    run_to_sc(u, c);
    chk("sc_period", c, F);
    chk("no_underrun", u, 0);
    check_frame("a5c3", 16'hA5C3);
    run_to_sc(u, c);
    audio_data = 16'h1234;
    run_to_sc(u, c);
    data_valid = 0;
    run_to_sc(u, c);
    chk("underrun_once", u, 1);
    chk("sc_period_underrun", c, F);
    check_frame("repeat_1234", 16'h1234);
    run_to_sc(u, c);
    mute = 1; audio_data = 16'h7FFF; data_valid = 1;
    run_to_sc(u, c);
    chk("mute_no_underrun", u, 0);
    mute = 0;
    check_frame("muted", 16'h0000);
    run_to_sc(u, c);
    check_frame("unmuted", 16'h7FFF);
    run_to_sc(u, c);
    audio_data = 16'hBEEF;
    repeat (40 * 2 * D) @(negedge Clk);
    enable = 0;
    @(negedge Clk);
    chk("drop_bclk", AUD_BCLK, 0);
    chk("drop_lrck", AUD_DACLRCK, 0);
    chk("drop_dat", AUD_DACDAT, 0);
    z = 0;
    repeat (F + 76) begin
      @(negedge Clk);
      if (sample_clk) z++;
    end
    chk("no_sc_idle", z, 0);
    enable = 1;
    @(negedge Clk);
    check_frame("reenable", 16'hBEEF);
    for (int i = 0; i < 12; i++) begin
      run_to_sc(u, c);
      audio_data = W'($urandom);
      data_valid = $urandom_range(0, 3) != 0;
      mute = $urandom_range(0, 5) == 0;
      repeat ($urandom_range(0, 400)) @(negedge Clk);
    end
    run_to_sc(u, c);
    repeat (3 * D + 3) @(negedge Clk);
    #2 Reset = 0; enable = 0;
    #1;
    chk("async_bclk", AUD_BCLK, 0);
    chk("async_lrck", AUD_DACLRCK, 0);
    chk("async_dat", AUD_DACDAT, 0);
    chk("async_sc", sample_clk, 0);
    @(negedge Clk);
    #2 Reset = 1; data_valid = 0; mute = 0;
    @(negedge Clk);
    first_rise();
    run_to_sc(u, c);
    chk("rerun_underrun", u, 1);
    run_to_sc(u, c);
    chk("rerun_sc_period", c, F);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
